// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bundle for the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a;
    logic             borrow;
    logic             ovf;
    modport master(output start, c, b, input busy, done, a, borrow, ovf);
    modport slave(input start, c, b, output busy, done, a, borrow, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a = c - b, LSB first, ripple borrow in a flop; `SUB_SAT_EN saturates a
module serial_subtractor #(parameter int WIDTH = 4) (
    input  logic clk,
    input  logic rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH:0]   cs, bs;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    logic             br, d, brn;
    logic [WIDTH:0]   rn;
    logic [WIDTH-1:0] res;
    // full-subtractor bit; r keeps the newest WIDTH difference bits, so {d, r} is the whole result on the last bit
    always_comb begin
        d   = cs[0] ^ bs[0] ^ br;
        brn = (~cs[0] & bs[0]) | (~(cs[0] ^ bs[0]) & br);
        rn  = {d, r};
`ifdef SUB_SAT_EN
        res = brn ? '0 : d ? '1 : rn[WIDTH-1:0];
`else
        res = rn[WIDTH-1:0];
`endif
    end
    // control FSM, shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cs         <= '0;
            bs         <= '0;
            r          <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.a      <= '0;
            bus.borrow <= 1'b0;
            bus.ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cs       <= bus.c;
                    bs       <= {1'b0, bus.b};
                    cnt      <= '0;
                    br       <= 1'b0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    cs  <= cs >> 1;
                    bs  <= bs >> 1;
                    r   <= rn[WIDTH:1];
                    br  <= brn;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH)) begin
                        bus.done   <= 1'b1;
                        bus.a      <= res;
                        bus.borrow <= brn;
                        bus.ovf    <= ~brn & d;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=4), honours `SUB_SAT_EN
module tb_serial_subtractor;
    typedef struct packed {
        logic [3:0] a;
        logic       bo;
        logic       ov;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mcnt = 0;
    exp_t sb[$];
    exp_t last = '0;
    serial_subtractor_if #(.WIDTH(4)) sif();
    serial_subtractor #(.WIDTH(4)) dut(.clk(clk), .rst_n(rst_n), .bus(sif));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t model(input logic [4:0] c, input logic [3:0] b);
        exp_t e;
        int   df;
        df   = int'(c) - int'(b);
        e.bo = df < 0;
        e.ov = !e.bo && df >= 16;
        e.a  = df[3:0];
`ifdef SUB_SAT_EN
        if (e.bo) e.a = 4'h0;
        else if (e.ov) e.a = 4'hF;
`endif
        return e;
    endfunction
    // cycle model of the handshake: 1 on acceptance, busy through 6, done at 6, idle after 7
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else if (mcnt == 0 && sif.start) begin
            mcnt <= 1;
            sb.push_back(model(sif.c, sif.b));
        end else if (mcnt != 0) mcnt <= (mcnt == 6) ? 0 : mcnt + 1;
    end
    // monitor: handshake timing every cycle, results against scoreboard on done, hold otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            last = '0;
            sb.delete();
        end else begin
            check("busy", sif.busy, mcnt != 0);
            check("done", sif.done, mcnt == 6);
            if (sif.done) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    last = sb.pop_front();
                    check("a", sif.a, last.a);
                    check("borrow", sif.borrow, last.bo);
                    check("ovf", sif.ovf, last.ov);
                end
            end else begin
                check("a_hold", sif.a, last.a);
                check("flag_hold", {sif.borrow, sif.ovf}, {last.bo, last.ov});
            end
        end
    end
    task automatic wait_idle();
        int n = 0;
        while (mcnt != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", mcnt, 0);
    endtask
    task automatic op(input logic [4:0] c, input logic [3:0] b);
        @(negedge clk);
        sif.start = 1'b1;
        sif.c = c;
        sif.b = b;
        @(negedge clk);
        sif.start = 1'b0;
        sif.c = ~c;
        sif.b = ~b;
        wait_idle();
    endtask
    task automatic check_zero(input string tag);
        check(tag, {sif.busy, sif.done, sif.a, sif.borrow, sif.ovf}, 0);
    endtask
    initial begin
        sif.start = 1'b0;
        sif.c = '0;
        sif.b = '0;
        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("reset_state");
        op(5'd20, 4'd7);
        op(5'd3, 4'd9);
        op(5'd30, 4'd2);
        op(5'd0, 4'd0);
        op(5'd31, 4'd0);
        op(5'd0, 4'd15);
        @(negedge clk);
        sif.start = 1'b1;
        sif.c = 5'd20;
        sif.b = 4'd7;
        @(negedge clk);
        sif.c = 5'd9;
        sif.b = 4'd4;
        repeat (7) @(negedge clk);
        sif.start = 1'b0;
        wait_idle();
        check("held_start_ops", n_tests > 0 && last.a == 4'd5, 1);
        @(negedge clk);
        sif.start = 1'b1;
        sif.c = 5'd25;
        sif.b = 4'd10;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midop");
        check("reset_model", mcnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("reset_release");
        op(5'd25, 4'd10);
        check("after_reset_a", last.a, 4'd15);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                op(5'(i + j), 4'(j));
                check("roundtrip", {last.a, last.bo, last.ov}, {4'(i), 2'b00});
            end
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
